// File: rtl/sync_arbiter.sv
// sync_arbiter: round-robin arbiter that serialises per-bank emulation-cache
// sync requests (fill / writeback) onto a single AXI master port, one INCR
// burst of BEATS beats per cache row, with a one-cycle done pulse per bank.
// Optional feature macro: SYNC_WB_PRIORITY_EN (writebacks win over fills).
module sync_arbiter #(
    parameter int BGWIDTH        = 2,
    parameter int BAWIDTH        = 2,
    parameter int ADDRWIDTH      = 17,
    parameter int CHWIDTH        = 6,
    parameter int BEATS          = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    localparam int BW     = BGWIDTH + BAWIDTH,
    localparam int NBANKS = 2 ** BW,
    localparam int BEATW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NBANKS-1:0]             req,
    input  logic [NBANKS-1:0]             req_wr,
    input  logic [NBANKS*ADDRWIDTH-1:0]   req_row,
    input  logic [NBANKS*CHWIDTH-1:0]     req_crow,
    output logic [NBANKS-1:0]             done,
    output logic                          err,
    output logic                          busy,
    output logic                          cache_en,
    output logic                          cache_we,
    output logic [BW-1:0]                 cache_bank,
    output logic [CHWIDTH-1:0]            cache_crow,
    output logic [BEATW-1:0]              cache_beat,
    output logic [AXI_DATA_WIDTH-1:0]     cache_wdata,
    input  logic [AXI_DATA_WIDTH-1:0]     cache_rdata,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic                          m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic                          m_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid
);

    localparam int STRBW      = AXI_DATA_WIDTH / 8;
    localparam int ADDR_SHIFT = $clog2(BEATS) + $clog2(STRBW);
    localparam int FULLW      = BW + ADDRWIDTH + ADDR_SHIFT;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_AW     = 4'd1;
    localparam logic [3:0] S_WFETCH = 4'd2;
    localparam logic [3:0] S_WCAP   = 4'd3;
    localparam logic [3:0] S_WSEND  = 4'd4;
    localparam logic [3:0] S_BRESP  = 4'd5;
    localparam logic [3:0] S_AR     = 4'd6;
    localparam logic [3:0] S_RDATA  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]                state;
    logic [BW-1:0]             rr_ptr;
    logic [BW-1:0]             bank_q;
    logic [ADDRWIDTH-1:0]      row_q;
    logic [CHWIDTH-1:0]        crow_q;
    logic [BEATW-1:0]          beat_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic                      err_q;
    logic                      rd_over_q;   // last slot written, burst still running

    logic [NBANKS-1:0]         eligible;
    logic                      grant_found;
    logic [BW-1:0]             grant_idx;
    logic [BW-1:0]             cand;
    logic                      beat_last;
    logic                      rd_write;
    logic [FULLW-1:0]          addr_full;
    logic [AXI_ADDR_WIDTH-1:0] axi_addr;

    // ID echoes are not checked; collected here so they have a sink.
    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid};

    // Eligible set: all requests, or writebacks only while any is pending.
    always_comb begin
`ifdef SYNC_WB_PRIORITY_EN
        eligible = (|(req & req_wr)) ? (req & req_wr) : req;
`else
        eligible = req;
`endif
    end

    // Round-robin search: first eligible bank at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NBANKS; i++) begin
            cand = rr_ptr + BW'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign beat_last = (beat_q == BEATW'(BEATS - 1));
    assign rd_write  = (state == S_RDATA) && m_axi_rvalid && !rd_over_q;
    assign addr_full = FULLW'({bank_q, row_q}) << ADDR_SHIFT;
    assign axi_addr  = AXI_ADDR_WIDTH'(addr_full);

    // Transaction FSM: grant, address phase, beat loop, response, done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            crow_q    <= '0;
            beat_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_over_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        bank_q    <= grant_idx;
                        row_q     <= req_row[grant_idx*ADDRWIDTH +: ADDRWIDTH];
                        crow_q    <= req_crow[grant_idx*CHWIDTH +: CHWIDTH];
                        beat_q    <= '0;
                        rd_over_q <= 1'b0;
                        state     <= req_wr[grant_idx] ? S_AW : S_AR;
                    end
                end
                S_AW:     if (m_axi_awready) state <= S_WFETCH;
                S_WFETCH: state <= S_WCAP;
                S_WCAP: begin
                    wdata_q <= cache_rdata;
                    state   <= S_WSEND;
                end
                S_WSEND: begin
                    if (m_axi_wready) begin
                        if (beat_last) begin
                            state <= S_BRESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            state  <= S_WFETCH;
                        end
                    end
                end
                S_BRESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_AR:     if (m_axi_arready) state <= S_RDATA;
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        if (m_axi_rresp != 2'b00 || rd_over_q) err_q <= 1'b1;
                        if (!rd_over_q) begin
                            if (!beat_last)         beat_q    <= beat_q + 1'b1;
                            else if (!m_axi_rlast)  rd_over_q <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            if (rd_over_q || !beat_last) err_q <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    err_q  <= 1'b0;
                    beat_q <= '0;
                    rr_ptr <= bank_q + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status, cache port and AXI outputs decoded from the current state.
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_DONE) ? (NBANKS'(1) << bank_q) : '0;
        err         = (state == S_DONE) && err_q;
        cache_en    = (state == S_WFETCH) || rd_write;
        cache_we    = rd_write;
        cache_bank  = bank_q;
        cache_crow  = crow_q;
        cache_beat  = beat_q;
        cache_wdata = m_axi_rdata;

        m_axi_awid    = AXI_ID_WIDTH'(bank_q);
        m_axi_awaddr  = axi_addr;
        m_axi_awlen   = 8'(BEATS - 1);
        m_axi_awsize  = 3'($clog2(STRBW));
        m_axi_awburst = 2'b01;
        m_axi_awlock  = 1'b0;
        m_axi_awcache = 4'b0011;
        m_axi_awprot  = 3'b000;
        m_axi_awvalid = (state == S_AW);

        m_axi_wdata   = wdata_q;
        m_axi_wstrb   = '1;
        m_axi_wvalid  = (state == S_WSEND);
        m_axi_wlast   = (state == S_WSEND) && beat_last;
        m_axi_bready  = (state == S_BRESP);

        m_axi_arid    = AXI_ID_WIDTH'(bank_q);
        m_axi_araddr  = axi_addr;
        m_axi_arlen   = 8'(BEATS - 1);
        m_axi_arsize  = 3'($clog2(STRBW));
        m_axi_arburst = 2'b01;
        m_axi_arlock  = 1'b0;
        m_axi_arcache = 4'b0011;
        m_axi_arprot  = 3'b000;
        m_axi_arvalid = (state == S_AR);
        m_axi_rready  = (state == S_RDATA);
    end

endmodule

// File: tb/tb_sync_arbiter.sv
// tb_sync_arbiter: randomized scoreboard bench for sync_arbiter. Stimulus
// pushes the expected grant sequence (from a round-robin model) into a queue;
// a monitor compares address phases, cache traffic, W beats and done pulses.
// Honors SYNC_WB_PRIORITY_EN in its reference model.
module tb_sync_arbiter;

    localparam int BEATS = 16;
    localparam int AW    = 17;
    localparam int CW    = 6;
    localparam int NB    = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NB-1:0]    req, req_wr;
    logic [NB*AW-1:0] req_row;
    logic [NB*CW-1:0] req_crow;
    logic [NB-1:0]    done;
    logic             err, busy, cache_en, cache_we;
    logic [3:0]       cache_bank;
    logic [CW-1:0]    cache_crow;
    logic [3:0]       cache_beat;
    logic [31:0]      cache_wdata, cache_rdata;
    logic [7:0]       awid, arid, bid, rid;
    logic [31:0]      awaddr, araddr, wdata, rdata;
    logic [7:0]       awlen, arlen;
    logic [2:0]       awsize, arsize, awprot, arprot;
    logic [1:0]       awburst, arburst, bresp, rresp;
    logic             awlock, arlock;
    logic [3:0]       awcache, arcache, wstrb;
    logic             awvalid, awready, wlast, wvalid, wready, bready, bvalid;
    logic             arvalid, arready, rready, rlast, rvalid;

    sync_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
        .req_row(req_row), .req_crow(req_crow), .done(done), .err(err), .busy(busy),
        .cache_en(cache_en), .cache_we(cache_we), .cache_bank(cache_bank),
        .cache_crow(cache_crow), .cache_beat(cache_beat), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rready(rready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        bit wr;
        int row;
        int crow;
        bit err;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    int   total = 0, bad = 0;
    int   model_ptr = 0;
    int   remain[NB];
    int   b_row[NB], b_crow[NB];
    int   rd_cnt = 0, wr_cnt = 0;
    bit   hold_v = 0;
    logic [32:0] hold_d;
    // slave behaviour knobs, fixed for the duration of a batch
    int   k_bad_beat = -1, k_rlast_beat = BEATS - 1, k_bresp = 0, k_wstall0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int b, input int row);
        longint a;
        a = ((longint'(b) << AW) + longint'(row)) * BEATS * 4;
        return a[31:0];
    endfunction

    function automatic logic [31:0] cache_pat(input int b, input int c, input int k);
        return {8'(b), 8'(c), 8'(k), 8'hC3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cache array model: read data appears the cycle after a read strobe.
    initial begin
        int b, c, k;
        cache_rdata = '0;
        forever begin
            @(posedge clk);
            if (cache_en && !cache_we) begin
                b = cache_bank; c = cache_crow; k = cache_beat;
                #1 cache_rdata = cache_pat(b, c, k);
            end
        end
    end

    // AXI write slave: AW accept, W beats with stalls, B response.
    initial begin
        int guard, st;
        bit ab;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        forever begin
            step();
            if (reset_n && awvalid) begin
                repeat ($urandom_range(0, 2)) step();
                awready = 1; step(); awready = 0;
                ab = 0;
                for (int k = 0; k < BEATS && !ab; k++) begin
                    guard = 0;
                    while (!wvalid && reset_n && guard < 50) begin step(); guard++; end
                    if (!reset_n || !wvalid) ab = 1;
                    else begin
                        st = (k == 0) ? k_wstall0 : $urandom_range(0, 1);
                        repeat (st) step();
                        wready = 1; step(); wready = 0;
                    end
                end
                if (!ab && reset_n) begin
                    repeat ($urandom_range(0, 2)) step();
                    bresp = 2'(k_bresp); bvalid = 1; step(); bvalid = 0; bresp = 0;
                end
            end
        end
    end

    // AXI read slave: AR accept, then beats 0..k_rlast_beat with random gaps.
    initial begin
        logic [31:0] base;
        bit ab;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        forever begin
            step();
            if (reset_n && arvalid) begin
                repeat ($urandom_range(0, 2)) step();
                arready = 1; base = araddr; step(); arready = 0;
                ab = 0;
                for (int k = 0; k <= k_rlast_beat && !ab; k++) begin
                    if ($urandom_range(0, 3) == 0) begin rvalid = 0; step(); end
                    if (!reset_n) ab = 1;
                    else begin
                        rvalid = 1;
                        rdata  = base ^ (32'(k) * 32'h01010101);
                        rresp  = (k == k_bad_beat) ? 2'd2 : 2'd0;
                        rlast  = (k == k_rlast_beat);
                        step();
                        if (!reset_n) ab = 1;
                    end
                end
                rvalid = 0; rlast = 0; rresp = 0;
            end
        end
    end

    // Monitor: compares everything the DUT presents against the scoreboard.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if ((arvalid && arready) || (awvalid && awready)) begin
                    check("addr_phase_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q[0];
                        check("direction", 64'(awvalid), 64'(cur.wr));
                        if (awvalid)
                            check("aw_fields", {awid, awaddr, awlen, awsize, awburst, awcache, awlock, awprot},
                                  {8'(cur.bank), exp_addr(cur.bank, cur.row), 8'd15, 3'd2, 2'd1, 4'b0011, 1'b0, 3'd0});
                        else
                            check("ar_fields", {arid, araddr, arlen, arsize, arburst, arcache, arlock, arprot},
                                  {8'(cur.bank), exp_addr(cur.bank, cur.row), 8'd15, 3'd2, 2'd1, 4'b0011, 1'b0, 3'd0});
                    end
                    rd_cnt = 0; wr_cnt = 0; hold_v = 0;
                end
                if (rvalid && rready) begin
                    if (rd_cnt < BEATS)
                        check("fill_write", {cache_en, cache_we, cache_bank, cache_crow, cache_beat, cache_wdata},
                              {2'b11, 4'(cur.bank), 6'(cur.crow), 4'(rd_cnt),
                               exp_addr(cur.bank, cur.row) ^ (32'(rd_cnt) * 32'h01010101)});
                    else
                        check("overrun_no_write", 64'(cache_en), 64'd0);
                    rd_cnt++;
                end else if (cache_we) begin
                    check("spurious_cache_write", 64'(cache_we), 64'd0);
                end
                if (cache_en && !cache_we)
                    check("wb_fetch", {cache_bank, cache_crow, cache_beat},
                          {4'(cur.bank), 6'(cur.crow), 4'(wr_cnt)});
                if (wvalid) begin
                    if (hold_v) check("w_hold_stable", {31'd0, wlast, wdata}, {31'd0, hold_d});
                    if (wready) begin
                        check("w_beat", {wstrb, wlast, wdata},
                              {4'hF, wr_cnt == BEATS - 1, cache_pat(cur.bank, cur.crow, wr_cnt)});
                        wr_cnt++;
                        hold_v = 0;
                    end else begin
                        hold_v = 1;
                        hold_d = {wlast, wdata};
                    end
                end
                if (done != 0) begin
                    if (exp_q.size() == 0) check("done_unexpected", 64'(done), 64'd0);
                    else begin
                        t = exp_q.pop_front();
                        check("done_bank", 64'(done), 64'(1) << t.bank);
                        check("done_err", 64'(err), 64'(t.err));
                        check("busy_at_done", 64'(busy), 64'd1);
                        if (t.wr) check("wb_beats", 64'(wr_cnt), 64'(BEATS));
                        else      check("fill_beats", 64'(rd_cnt), 64'(k_rlast_beat + 1));
                    end
                end else if (err) begin
                    check("err_without_done", 64'(err), 64'd0);
                end
            end
        end
    end

    task automatic do_reset();
        req = '0;
        reset_n = 0;
        exp_q.delete();
        model_ptr = 0;
        for (int b = 0; b < NB; b++) remain[b] = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        step();
    endtask

    // Raise a set of requests at once; model the grant order round-robin.
    task automatic start_batch(input bit [NB-1:0] banks, input bit [NB-1:0] wrs, input bit [NB-1:0] twice);
        int cnt[NB];
        int n, pick, idx;
        bit any_wb, rd_err, wr_err;
        txn_t t;
        rd_err = (k_bad_beat >= 0 && k_bad_beat <= k_rlast_beat) || (k_rlast_beat != BEATS - 1);
        wr_err = (k_bresp != 0);
        n = 0;
        for (int b = 0; b < NB; b++) begin
            cnt[b] = banks[b] ? (twice[b] ? 2 : 1) : 0;
            remain[b] = cnt[b];
            n += cnt[b];
            if (b_row[b] < 0) b_row[b] = 0;
        end
        for (int i = 0; i < n; i++) begin
            any_wb = 0;
`ifdef SYNC_WB_PRIORITY_EN
            for (int b = 0; b < NB; b++) if (cnt[b] > 0 && wrs[b]) any_wb = 1;
`endif
            pick = 0;
            for (int k = 0; k < NB; k++) begin
                idx = (model_ptr + k) % NB;
                if (cnt[idx] > 0 && (!any_wb || wrs[idx])) begin pick = idx; break; end
            end
            cnt[pick]--;
            t.bank = pick; t.wr = wrs[pick]; t.row = b_row[pick]; t.crow = b_crow[pick];
            t.err = wrs[pick] ? wr_err : rd_err;
            exp_q.push_back(t);
            model_ptr = (pick + 1) % NB;
        end
        @(posedge clk); #1;
        for (int b = 0; b < NB; b++) begin
            req_row[b*AW +: AW]  = AW'(b_row[b]);
            req_crow[b*CW +: CW] = CW'(b_crow[b]);
        end
        req_wr = wrs;
        req    = banks;
    endtask

    // Drop each request after its last done pulse; bounded by a cycle budget.
    task automatic wait_batch();
        int cyc, left;
        cyc = 0;
        left = 1;
        while (left != 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            left = 0;
            for (int b = 0; b < NB; b++) begin
                if (done[b] && remain[b] > 0) begin
                    remain[b]--;
                    if (remain[b] == 0) req[b] = 1'b0;
                end
                left += remain[b];
            end
        end
        check("batch_complete", 64'(left), 64'd0);
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        if (left != 0) do_reset();
    endtask

    task automatic set_rows(input int b, input int row, input int crow);
        b_row[b] = row; b_crow[b] = crow;
    endtask

    task automatic knobs(input int bad_beat, input int last_beat, input int br, input int st0);
        k_bad_beat = bad_beat; k_rlast_beat = last_beat; k_bresp = br; k_wstall0 = st0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [NB-1:0] bm, wm, tm;
        int hs, cyc;
        reset_n = 0; req = '0; req_wr = '0; req_row = '0; req_crow = '0;
        for (int b = 0; b < NB; b++) begin
            b_row[b] = $urandom_range(0, (1 << AW) - 1);
            b_crow[b] = $urandom_range(0, 63);
        end
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, err, cache_en, cache_we, arvalid, awvalid, wvalid, bready, rready, cache_beat},
              64'd0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, arvalid, awvalid}, 64'd0);

        // round-robin: 0 (twice), 1, 15 held from rr_ptr=0 -> 0,1,15,0
        knobs(-1, BEATS - 1, 0, 0);
        start_batch(16'h8003, 16'h0000, 16'h0001);
        wait_batch();

        // plan fill on bank 5, row 0x123, slot 3
        set_rows(5, 'h123, 3);
        start_batch(16'h0020, 16'h0000, 16'h0000);
        wait_batch();

        // writeback with wready held low 3 cycles on beat 0
        knobs(-1, BEATS - 1, 0, 3);
        start_batch(16'h0080, 16'h0080, 16'h0000);
        wait_batch();

        // fill on bank 2 vs writeback on bank 9 from rr_ptr=0
        do_reset();
        knobs(-1, BEATS - 1, 0, 0);
        start_batch(16'h0204, 16'h0200, 16'h0000);
        wait_batch();

        // error cases: rresp on beat 7, early rlast, late rlast, bad bresp
        knobs(7, BEATS - 1, 0, 0);
        start_batch(16'h0010, 16'h0000, 16'h0000); wait_batch();
        knobs(-1, 10, 0, 0);
        start_batch(16'h0100, 16'h0000, 16'h0000); wait_batch();
        knobs(-1, 18, 0, 0);
        start_batch(16'h1000, 16'h0000, 16'h0000); wait_batch();
        knobs(-1, BEATS - 1, 2, 1);
        start_batch(16'h0040, 16'h0040, 16'h0000); wait_batch();

        // reset during read beat 4, then bank 3 alone
        knobs(-1, BEATS - 1, 0, 0);
        start_batch(16'h0040, 16'h0000, 16'h0000);
        hs = 0; cyc = 0;
        while (cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (rvalid && rready) begin
                if (hs == 4) break;
                hs++;
            end
        end
        check("reached_beat4", 64'(hs), 64'd4);
        #2 reset_n = 0;
        #1 check("reset_mid_burst", {busy, done, err, cache_en, cache_we, arvalid, awvalid, wvalid, bready, rready},
                 64'd0);
        req = '0;
        exp_q.delete();
        model_ptr = 0;
        for (int b = 0; b < NB; b++) remain[b] = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        step();
        start_batch(16'h0008, 16'h0000, 16'h0000);
        wait_batch();

        // randomized batches
        for (int it = 0; it < 25; it++) begin
            bm = '0; wm = '0; tm = '0;
            for (int b = 0; b < NB; b++) begin
                bm[b] = ($urandom_range(0, 4) == 0);
                wm[b] = $urandom_range(0, 1);
                tm[b] = ($urandom_range(0, 3) == 0);
                b_row[b] = $urandom_range(0, (1 << AW) - 1);
                b_crow[b] = $urandom_range(0, 63);
            end
            if (bm == 0) bm[$urandom_range(0, NB - 1)] = 1'b1;
            case ($urandom_range(0, 5))
                0:       knobs($urandom_range(0, 15), BEATS - 1, 0, 0);
                1:       knobs(-1, $urandom_range(5, 20), 0, 1);
                2:       knobs(-1, BEATS - 1, $urandom_range(1, 3), 2);
                default: knobs(-1, BEATS - 1, 0, $urandom_range(0, 3));
            endcase
            start_batch(bm, wm, tm & bm);
            wait_batch();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
